// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/interrupt control block:
// FSM state encoding, default peripheral base address and field widths.
package cpu_ctrl_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned STALL_W   = 16;

  localparam logic [ADDR_W-1:0] PERIPH_BASE_DEF = 32'h4000_0000;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MWAIT  = 2'd1,
    ST_IENTER = 2'd2
  } hcu_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Loadable down-counter timing the remaining peripheral wait cycles.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   i_load       load i_load_val (has priority over decrement)
//   i_load_val   value to load
//   i_dec        decrement by one; ignored once the count is zero
//   o_zero       count is zero
module mem_wait_timer
  import cpu_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Count register; never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use stalls, branch/jump squashes,
// peripheral-access freezes and interrupt entry sequencing.
// Ports:
//   sysclk, reset              clock / async active-low reset
//   ID_*, EX_*, MEM_*          stage information used for hazard detection
//   IRQ, Kernel_Mode, IRQ_Done interrupt request, mask and re-arm
//   PC_Write .. WB_Bubble      combinational pipeline register controls
//   IRQ_Take                   one-cycle interrupt-entry tag for ID
//   Stall_Cnt                  saturating count of cycles with PC frozen
module hazard_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned       MEM_WAIT    = 2,
  parameter logic [ADDR_W-1:0] PERIPH_BASE = PERIPH_BASE_DEF
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] ID_Rs,
  input  logic [REG_IDX_W-1:0] ID_Rt,
  input  logic                 ID_UsesRt,
  input  logic                 ID_Jump,
  input  logic                 EX_MemRead,
  input  logic [REG_IDX_W-1:0] EX_Rt,
  input  logic                 EX_BranchTaken,
  input  logic                 MEM_MemAccess,
  input  logic [ADDR_W-1:0]    MEM_Addr,
  input  logic                 IRQ,
  input  logic                 Kernel_Mode,
  input  logic                 IRQ_Done,
  output logic                 PC_Write,
  output logic                 IF_ID_Write,
  output logic                 IF_Flush,
  output logic                 ID_Flush,
  output logic                 Pipe_Hold,
  output logic                 WB_Bubble,
  output logic                 IRQ_Take,
  output logic [STALL_W-1:0]   Stall_Cnt
);

  localparam bit               WAIT_EN   = (MEM_WAIT != 0);
  // The detection cycle in RUN counts as the first wait cycle.
  localparam logic [CNT_W-1:0] WAIT_LOAD = WAIT_EN ? CNT_W'(MEM_WAIT - 1) : '0;

  hcu_state_e         r_state, w_next_state;
  logic               r_irq_busy;
  logic [STALL_W-1:0] r_stall_cnt;
  logic               w_mem_hit, w_lu, w_cnt_zero, w_cnt_load, w_cnt_dec;

  assign w_mem_hit = WAIT_EN && MEM_MemAccess && (MEM_Addr >= PERIPH_BASE);
  assign w_lu      = EX_MemRead && (EX_Rt != '0) &&
                     ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

  mem_wait_timer u_mem_wait_timer (
    .clk        (sysclk),
    .rst_n      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (WAIT_LOAD),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // State register.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_next_state;
  end

  // Next state and pipeline controls.
  always_comb begin
    w_next_state = r_state;
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_Flush     = 1'b0;
    ID_Flush     = 1'b0;
    Pipe_Hold    = 1'b0;
    WB_Bubble    = 1'b0;
    IRQ_Take     = 1'b0;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_mem_hit) begin
          PC_Write     = 1'b0;
          IF_ID_Write  = 1'b0;
          Pipe_Hold    = 1'b1;
          WB_Bubble    = 1'b1;
          w_cnt_load   = 1'b1;
          w_next_state = ST_MWAIT;
        end else if (EX_BranchTaken) begin
          IF_Flush = 1'b1;
          ID_Flush = 1'b1;
        end else if (w_lu) begin
          PC_Write    = 1'b0;
          IF_ID_Write = 1'b0;
          ID_Flush    = 1'b1;
        end else if (ID_Jump) begin
          IF_Flush = 1'b1;
        end else if (IRQ && !Kernel_Mode && !r_irq_busy) begin
          w_next_state = ST_IENTER;
        end
      end
      ST_MWAIT: begin
        // Hazard inputs are ignored while the pipeline is frozen.
        if (!w_cnt_zero) begin
          PC_Write    = 1'b0;
          IF_ID_Write = 1'b0;
          Pipe_Hold   = 1'b1;
          WB_Bubble   = 1'b1;
          w_cnt_dec   = 1'b1;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_IENTER: begin
        IRQ_Take     = 1'b1;
        IF_Flush     = 1'b1;
        w_next_state = ST_RUN;
      end
      default: w_next_state = ST_RUN;
    endcase
  end

  // Interrupt re-arm flag; a set in IENTER beats a coincident IRQ_Done.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)                    r_irq_busy <= 1'b0;
    else if (r_state == ST_IENTER) r_irq_busy <= 1'b1;
    else if (IRQ_Done)             r_irq_busy <= 1'b0;
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)                                  r_stall_cnt <= '0;
    else if (!PC_Write && (r_stall_cnt != '1))   r_stall_cnt <= r_stall_cnt + STALL_W'(1);
  end

  assign Stall_Cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

  logic        sysclk = 1'b0;
  logic        reset;
  logic [4:0]  ID_Rs, ID_Rt, EX_Rt;
  logic        ID_UsesRt, ID_Jump, EX_MemRead, EX_BranchTaken;
  logic        MEM_MemAccess;
  logic [31:0] MEM_Addr;
  logic        IRQ, Kernel_Mode, IRQ_Done;
  logic        PC_Write, IF_ID_Write, IF_Flush, ID_Flush, Pipe_Hold, WB_Bubble, IRQ_Take;
  logic [15:0] Stall_Cnt;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;

  hazard_control_unit #(.MEM_WAIT(2), .PERIPH_BASE(32'h4000_0000)) dut (
    .sysclk(sysclk), .reset(reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt), .ID_Jump(ID_Jump),
    .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .EX_BranchTaken(EX_BranchTaken),
    .MEM_MemAccess(MEM_MemAccess), .MEM_Addr(MEM_Addr),
    .IRQ(IRQ), .Kernel_Mode(Kernel_Mode), .IRQ_Done(IRQ_Done),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_Flush(IF_Flush),
    .ID_Flush(ID_Flush), .Pipe_Hold(Pipe_Hold), .WB_Bubble(WB_Bubble),
    .IRQ_Take(IRQ_Take), .Stall_Cnt(Stall_Cnt)
  );

  always #5 sysclk = ~sysclk;

  // Advance to 1 time unit after the next rising edge; inputs change here.
  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic clear_inputs();
    ID_Rs = '0; ID_Rt = '0; ID_UsesRt = 0; ID_Jump = 0;
    EX_MemRead = 0; EX_Rt = '0; EX_BranchTaken = 0;
    MEM_MemAccess = 0; MEM_Addr = '0;
    IRQ = 0; Kernel_Mode = 0; IRQ_Done = 0;
  endtask

  // Packs {PC_Write, IF_ID_Write, IF_Flush, ID_Flush, Pipe_Hold, WB_Bubble, IRQ_Take}.
  function automatic logic [6:0] ctl();
    return {PC_Write, IF_ID_Write, IF_Flush, ID_Flush, Pipe_Hold, WB_Bubble, IRQ_Take};
  endfunction

  localparam logic [6:0] C_DEF   = 7'b1100000;
  localparam logic [6:0] C_HOLD  = 7'b0000110;
  localparam logic [6:0] C_LU    = 7'b0001000;
  localparam logic [6:0] C_BR    = 7'b1111000;
  localparam logic [6:0] C_JMP   = 7'b1110000;
  localparam logic [6:0] C_IRQ   = 7'b1110001;

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    #3;
    checks++;
    if (ctl() !== C_DEF) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl(), C_DEF); end
    checks++;
    if (Stall_Cnt !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", Stall_Cnt); end
    step();
    reset = 1;
    step();
    checks++;
    if (ctl() !== C_DEF) begin errors++; $display("FAIL post_reset_ctl: got %b expected %b", ctl(), C_DEF); end
  endtask

  task automatic test_load_use();
    EX_MemRead = 1; EX_Rt = 5'd8; ID_Rs = 5'd8;
    #2;
    checks++;
    if (ctl() !== C_LU) begin errors++; $display("FAIL lu_stall: got %b expected %b", ctl(), C_LU); end
    exp_stall++;
    step();
    clear_inputs();
    #2;
    checks++;
    if (ctl() !== C_DEF) begin errors++; $display("FAIL lu_release: got %b expected %b", ctl(), C_DEF); end
    checks++;
    if (Stall_Cnt !== 16'(exp_stall)) begin errors++; $display("FAIL lu_stall_cnt: got %0d expected %0d", Stall_Cnt, exp_stall); end
    EX_MemRead = 1; EX_Rt = 5'd0; ID_Rs = 5'd0;
    #2;
    checks++;
    if (ctl() !== C_DEF) begin errors++; $display("FAIL lu_r0: got %b expected %b", ctl(), C_DEF); end
    EX_Rt = 5'd5; ID_Rs = 5'd3; ID_Rt = 5'd5; ID_UsesRt = 0;
    #2;
    checks++;
    if (ctl() !== C_DEF) begin errors++; $display("FAIL lu_rt_unused: got %b expected %b", ctl(), C_DEF); end
    ID_UsesRt = 1;
    #2;
    checks++;
    if (ctl() !== C_LU) begin errors++; $display("FAIL lu_rt_used: got %b expected %b", ctl(), C_LU); end
    exp_stall++;
    step();
    clear_inputs();
    #2;
    checks++;
    if (Stall_Cnt !== 16'(exp_stall)) begin errors++; $display("FAIL lu_rt_stall_cnt: got %0d expected %0d", Stall_Cnt, exp_stall); end
  endtask

  task automatic test_branch_jump();
    EX_MemRead = 1; EX_Rt = 5'd8; ID_Rs = 5'd8; EX_BranchTaken = 1; ID_Jump = 1;
    #2;
    checks++;
    if (ctl() !== C_BR) begin errors++; $display("FAIL branch_over_lu: got %b expected %b", ctl(), C_BR); end
    step();
    clear_inputs();
    ID_Jump = 1;
    #2;
    checks++;
    if (ctl() !== C_JMP) begin errors++; $display("FAIL jump: got %b expected %b", ctl(), C_JMP); end
    step();
    clear_inputs();
  endtask

  task automatic test_periph();
    MEM_MemAccess = 1; MEM_Addr = 32'h0000_0010;
    #2;
    checks++;
    if (ctl() !== C_DEF) begin errors++; $display("FAIL periph_ram: got %b expected %b", ctl(), C_DEF); end
    MEM_Addr = 32'h3FFF_FFFF;
    #2;
    checks++;
    if (ctl() !== C_DEF) begin errors++; $display("FAIL periph_below_base: got %b expected %b", ctl(), C_DEF); end
    MEM_Addr = 32'h4000_000C;
    EX_BranchTaken = 1;
    #2;
    checks++;
    if (ctl() !== C_HOLD) begin errors++; $display("FAIL periph_hold0: got %b expected %b", ctl(), C_HOLD); end
    step();
    exp_stall++;
    // Branch stays asserted but must be ignored during the hold.
    MEM_MemAccess = 0;
    #2;
    checks++;
    if (ctl() !== C_HOLD) begin errors++; $display("FAIL periph_hold1: got %b expected %b", ctl(), C_HOLD); end
    step();
    exp_stall++;
    clear_inputs();
    #2;
    checks++;
    if (ctl() !== C_DEF) begin errors++; $display("FAIL periph_end: got %b expected %b", ctl(), C_DEF); end
    checks++;
    if (Stall_Cnt !== 16'(exp_stall)) begin errors++; $display("FAIL periph_stall_cnt: got %0d expected %0d", Stall_Cnt, exp_stall); end
    step();
    MEM_MemAccess = 1; MEM_Addr = 32'h4000_0000;
    #2;
    checks++;
    if (ctl() !== C_HOLD) begin errors++; $display("FAIL periph_at_base: got %b expected %b", ctl(), C_HOLD); end
    step();
    exp_stall++;
    clear_inputs();
    step();
    exp_stall++;
    step();
  endtask

  task automatic test_irq_mwait();
    MEM_MemAccess = 1; MEM_Addr = 32'h4000_0010; IRQ = 1;
    #2;
    checks++;
    if (ctl() !== C_HOLD) begin errors++; $display("FAIL irq_hold_c0: got %b expected %b", ctl(), C_HOLD); end
    step(); exp_stall++;
    MEM_MemAccess = 0;
    step(); exp_stall++;
    #2;
    checks++;
    if (ctl() !== C_DEF) begin errors++; $display("FAIL irq_hold_end_c2: got %b expected %b", ctl(), C_DEF); end
    step();
    #2;
    checks++;
    if (IRQ_Take !== 1'b0) begin errors++; $display("FAIL irq_c3_early: got %b expected 0", IRQ_Take); end
    step();
    #2;
    checks++;
    if (ctl() !== C_IRQ) begin errors++; $display("FAIL irq_take_c4: got %b expected %b", ctl(), C_IRQ); end
    for (int i = 0; i < 4; i++) begin
      step();
      #2;
      checks++;
      if (IRQ_Take !== 1'b0) begin errors++; $display("FAIL irq_no_repeat[%0d]: got %b expected 0", i, IRQ_Take); end
    end
    IRQ_Done = 1;
    step();
    IRQ_Done = 0;
    #2;
    checks++;
    if (IRQ_Take !== 1'b0) begin errors++; $display("FAIL irq_rearm_entry: got %b expected 0", IRQ_Take); end
    step();
    #2;
    checks++;
    if (IRQ_Take !== 1'b1) begin errors++; $display("FAIL irq_rearm_take: got %b expected 1", IRQ_Take); end
    IRQ = 0;
    step();
    IRQ_Done = 1;
    step();
    IRQ_Done = 0;
  endtask

  task automatic test_kernel();
    IRQ = 1; Kernel_Mode = 1;
    for (int i = 0; i < 10; i++) begin
      #2;
      checks++;
      if (IRQ_Take !== 1'b0) begin errors++; $display("FAIL kernel_block[%0d]: got %b expected 0", i, IRQ_Take); end
      step();
    end
    Kernel_Mode = 0;
    #2;
    checks++;
    if (IRQ_Take !== 1'b0) begin errors++; $display("FAIL kernel_drop_same: got %b expected 0", IRQ_Take); end
    step();
    #2;
    checks++;
    if (IRQ_Take !== 1'b1) begin errors++; $display("FAIL kernel_drop_take: got %b expected 1", IRQ_Take); end
    IRQ = 0;
    step();
    IRQ_Done = 1;
    step();
    IRQ_Done = 0;
  endtask

  task automatic test_reset_mwait();
    MEM_MemAccess = 1; MEM_Addr = 32'h4000_0004;
    step();
    MEM_MemAccess = 0;
    #2;
    checks++;
    if (ctl() !== C_HOLD) begin errors++; $display("FAIL rst_mwait_pre: got %b expected %b", ctl(), C_HOLD); end
    reset = 0;
    #1;
    checks++;
    if (PC_Write !== 1'b1 || Pipe_Hold !== 1'b0) begin
      errors++; $display("FAIL rst_mwait_ctl: got PC_Write=%b Pipe_Hold=%b expected 1/0", PC_Write, Pipe_Hold);
    end
    checks++;
    if (Stall_Cnt !== 16'd0) begin errors++; $display("FAIL rst_mwait_stall: got %0d expected 0", Stall_Cnt); end
    exp_stall = 0;
    step();
    reset = 1;
    step();
    #2;
    checks++;
    if (ctl() !== C_DEF) begin errors++; $display("FAIL rst_mwait_after: got %b expected %b", ctl(), C_DEF); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_jump();
    test_periph();
    checks++;
    if (Stall_Cnt !== 16'(exp_stall)) begin errors++; $display("FAIL stall_total: got %0d expected %0d", Stall_Cnt, exp_stall); end
    test_irq_mwait();
    test_kernel();
    test_reset_mwait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
